// File: rtl/fifo_burst_pkg.sv
// Shared types and elaboration helpers for the FIFO burst reader.
package fifo_burst_pkg;

    // Reader control states: waiting for a burst trigger, or draining a burst.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_e;

    // A burst can never be longer than the FIFO that feeds it.
    function automatic bit burst_len_ok(input int unsigned burst_len,
                                        input int unsigned fifo_depth);
        return (burst_len >= 1) && (burst_len <= fifo_depth);
    endfunction

endpackage

// File: rtl/generic_sync_fifo.sv
// Synchronous show-ahead FIFO: rdata presents the head word whenever !empty,
// count is the registered occupancy.
module generic_sync_fifo #(
    parameter type         DTYPE      = logic [7:0],
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wen,
    input  DTYPE                wdata,
    output logic                full,
    input  logic                ren,
    output DTYPE                rdata,
    output logic                empty,
    output logic [ADDR_WIDTH:0] count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    DTYPE                  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign do_wr = wen && !full;
    assign do_rd = ren && !empty;
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign rdata = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master for a show-ahead FIFO: pops words and emits them as
// fixed-length valid/ready bursts with a last marker, or as a short flush
// burst once a partial fill has waited TIMEOUT cycles.
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter type         DTYPE      = logic [7:0],
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                fifo_ren,
    input  DTYPE                fifo_rdata,
    input  logic                fifo_empty,
    input  logic [ADDR_WIDTH:0] fifo_count,
    output logic                m_valid,
    input  logic                m_ready,
    output DTYPE                m_data,
    output logic                m_last,
    output logic                busy
);

    // A zero TIMEOUT still needs a one-bit counter so the logic stays legal.
    localparam int unsigned         WAIT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit                  FLUSH_EN    = (TIMEOUT != 0);
    localparam logic [WAIT_W-1:0]   WAIT_MAX    = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
    localparam logic [ADDR_WIDTH:0] BURST_LEN_C = (ADDR_WIDTH + 1)'(BURST_LEN);
    localparam logic [ADDR_WIDTH:0] ONE_BEAT    = (ADDR_WIDTH + 1)'(1);

    if (!burst_len_ok(BURST_LEN, FIFO_DEPTH)) begin : g_bad_burst_len
        $error("fifo_burst_reader: BURST_LEN must lie in 1..FIFO_DEPTH");
    end

    burst_state_e        state;
    logic [ADDR_WIDTH:0] beats_left;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                load;

    // Pop when the output register is free or draining this cycle. Reset
    // masks the pop so words behind an abandoned burst stay in the FIFO.
    assign load     = !rst && (state == BURST) && (!m_valid || m_ready)
                      && (beats_left != '0) && !fifo_empty;
    assign fifo_ren = load;
    assign busy     = (state == BURST);

    // Burst control FSM with the registered output stage folded in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beats_left <= '0;
            wait_cnt   <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_data     <= '0;
        end else begin
            if (m_valid && m_ready && !load) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en && (fifo_count >= BURST_LEN_C)) begin
                        beats_left <= BURST_LEN_C;
                        wait_cnt   <= '0;
                        state      <= BURST;
                    end else if (en && !fifo_empty && FLUSH_EN && (wait_cnt == WAIT_MAX)) begin
                        beats_left <= fifo_count;
                        wait_cnt   <= '0;
                        state      <= BURST;
                    end else if (en && !fifo_empty) begin
                        if (wait_cnt != WAIT_MAX) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end

                BURST: begin
                    if (load) begin
                        m_data     <= fifo_rdata;
                        m_valid    <= 1'b1;
                        m_last     <= (beats_left == ONE_BEAT);
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == ONE_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // The FIFO must never run dry while beats are still owed.
    burst_never_sees_empty: assert property (
        @(posedge clk) disable iff (rst)
        ((state == BURST) && (beats_left != '0)) |-> !fifo_empty
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader attached to generic_sync_fifo: a table of
// burst scenarios, directed corner sequences and a randomized phase, all
// checked against a word-order scoreboard and expected burst lengths.
module tb_fifo_burst_reader;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int          BL    = 8;
    localparam int          TO    = 16;

    typedef logic [7:0] word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst      = 1'b1;
    logic  fifo_rst = 1'b1;
    logic  en       = 1'b1;
    logic  m_ready  = 1'b1;
    logic  wen      = 1'b0;
    logic  wen_b    = 1'b0;
    word_t wdata    = '0;

    logic        full_a, empty_a, ren_a, m_valid_a, m_last_a, busy_a;
    word_t       rdata_a, m_data_a;
    logic [AW:0] count_a;

    logic        full_b, empty_b, ren_b, m_valid_b, m_last_b, busy_b;
    word_t       rdata_b, m_data_b;
    logic [AW:0] count_b;

    generic_sync_fifo #(.DTYPE(word_t), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .rst(fifo_rst), .wen(wen), .wdata(wdata), .full(full_a),
        .ren(ren_a), .rdata(rdata_a), .empty(empty_a), .count(count_a)
    );

    fifo_burst_reader #(.DTYPE(word_t), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(TO)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .fifo_ren(ren_a), .fifo_rdata(rdata_a),
        .fifo_empty(empty_a), .fifo_count(count_a), .m_valid(m_valid_a),
        .m_ready(m_ready), .m_data(m_data_a), .m_last(m_last_a), .busy(busy_a)
    );

    generic_sync_fifo #(.DTYPE(word_t), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .rst(fifo_rst), .wen(wen_b), .wdata(wdata), .full(full_b),
        .ren(ren_b), .rdata(rdata_b), .empty(empty_b), .count(count_b)
    );

    fifo_burst_reader #(.DTYPE(word_t), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(0)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .fifo_ren(ren_b), .fifo_rdata(rdata_b),
        .fifo_empty(empty_b), .fifo_count(count_b), .m_valid(m_valid_b),
        .m_ready(1'b1), .m_data(m_data_b), .m_last(m_last_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic void check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endfunction

    // Scoreboard: words in push order, and the burst lengths the stream must show.
    word_t exp_q[$];
    int    blen_q[$];
    int    beat_idx  = 0;
    int    acc_cnt   = 0;
    int    last_cnt  = 0;
    int    ren_cnt_a = 0;
    int    b_valid_seen = 0;
    int    b_ren_seen   = 0;
    bit    mon_on    = 1'b0;

    always @(negedge clk) begin
        bit exp_last;
        if (mon_on && m_valid_a) begin
            exp_last = (blen_q.size() > 0) && (beat_idx + 1 == blen_q[0]);
            check_eq("beat_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check_eq("m_data", m_data_a, exp_q[0]);
            check_eq("m_last", m_last_a, exp_last);
            if (m_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                acc_cnt++;
                if (m_last_a) last_cnt++;
                if (exp_last) begin
                    void'(blen_q.pop_front());
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
        end
        if (ren_a) ren_cnt_a++;
        if (m_valid_b) b_valid_seen++;
        if (ren_b) b_ren_seen++;
    end

    // Downstream ready: 0 = 4-cycle pattern, 1 = random, 2 = always ready.
    int          rdy_mode = 2;
    logic [3:0]  rdy_pat  = 4'b1111;
    int unsigned rdy_ph   = 0;

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: begin
                m_ready = rdy_pat[rdy_ph % 4];
                rdy_ph++;
            end
            1: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b1;
        endcase
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t, limit 2000000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_n(input int n, input word_t base);
        for (int i = 0; i < n; i++) begin
            while (full_a) tick();
            wen   = 1'b1;
            wdata = base + word_t'(i);
            exp_q.push_back(wdata);
            tick();
        end
        wen = 1'b0;
    endtask

    task automatic expect_bursts(input int n);
        int rem = n;
        while (rem >= BL) begin
            blen_q.push_back(BL);
            rem -= BL;
        end
        if (rem > 0) blen_q.push_back(rem);
    endtask

    task automatic drain(input int budget, input string name);
        int c = 0;
        while ((exp_q.size() != 0 || blen_q.size() != 0 || m_valid_a) && c < budget) begin
            tick();
            c++;
        end
        check_range(name, c, 0, budget - 1);
        exp_q.delete();
        blen_q.delete();
        beat_idx = 0;
    endtask

    typedef struct {
        int         nwords;
        word_t      base;
        logic [3:0] pat;
        int         nbursts;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int c;
        int vcyc;
        int gaps;
        int gap;
        int maxgap;
        bit started;
        bit done;

        vecs[0] = '{nwords: 8,  base: 8'h10, pat: 4'b1111, nbursts: 1};
        vecs[1] = '{nwords: 16, base: 8'h40, pat: 4'b1001, nbursts: 2};
        vecs[2] = '{nwords: 3,  base: 8'hA0, pat: 4'b1111, nbursts: 1};
        vecs[3] = '{nwords: 24, base: 8'h60, pat: 4'b0101, nbursts: 3};
        vecs[4] = '{nwords: 13, base: 8'hC0, pat: 4'b1011, nbursts: 2};

        // Reset state
        repeat (3) tick();
        check_eq("rst_m_valid", m_valid_a, 0);
        check_eq("rst_m_last", m_last_a, 0);
        check_eq("rst_m_data", m_data_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_fifo_ren", ren_a, 0);
        rst = 1'b0;
        fifo_rst = 1'b0;
        tick();
        mon_on = 1'b1;

        // Table-driven burst scenarios
        foreach (vecs[v]) begin
            acc_cnt = 0;
            last_cnt = 0;
            rdy_pat = vecs[v].pat;
            rdy_ph = 0;
            rdy_mode = 0;
            expect_bursts(vecs[v].nwords);
            write_n(vecs[v].nwords, vecs[v].base);
            drain(400, "vec_drain");
            check_eq("vec_beats", acc_cnt, vecs[v].nwords);
            check_eq("vec_lasts", last_cnt, vecs[v].nbursts);
            check_eq("vec_fifo_empty", empty_a, 1);
        end
        rdy_mode = 2;
        tick();

        // Full burst: pop latency, 8 back-to-back beats, busy low on last beat
        acc_cnt = 0;
        last_cnt = 0;
        expect_bursts(8);
        write_n(8, 8'h10);
        c = 0;
        while (!ren_a && c < 10) begin
            tick();
            c++;
        end
        check_range("full_ren_latency", c, 1, 2);
        vcyc = 0;
        gaps = 0;
        started = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (m_valid_a) begin
                started = 1'b1;
                vcyc++;
                if (m_last_a) begin
                    check_eq("full_busy_at_last", busy_a, 0);
                    done = 1'b1;
                end
            end else if (started) begin
                gaps++;
            end
            tick();
        end
        check_eq("full_last_seen", done, 1);
        check_eq("full_valid_cycles", vcyc, 8);
        check_eq("full_gaps", gaps, 0);
        drain(40, "full_drain");

        // Flush timeout on A, and no flush at all with TIMEOUT=0 on B
        acc_cnt = 0;
        last_cnt = 0;
        expect_bursts(3);
        for (int i = 0; i < 3; i++) begin
            wen = 1'b1;
            wen_b = 1'b1;
            wdata = 8'hA0 + word_t'(i);
            exp_q.push_back(wdata);
            tick();
        end
        wen = 1'b0;
        wen_b = 1'b0;
        c = 2;
        while (!ren_a && c < 40) begin
            tick();
            c++;
        end
        check_eq("flush_delay", c, TO);
        drain(40, "flush_drain");
        check_eq("flush_beats", acc_cnt, 3);
        check_eq("flush_lasts", last_cnt, 1);
        repeat (20) tick();
        check_eq("noflush_valid", b_valid_seen, 0);
        check_eq("noflush_ren", b_ren_seen, 0);
        check_eq("noflush_count", count_b, 3);

        // en gating, then en dropped mid-burst
        acc_cnt = 0;
        last_cnt = 0;
        en = 1'b0;
        expect_bursts(8);
        write_n(8, 8'h50);
        ren_cnt_a = 0;
        repeat (30) tick();
        check_eq("en_low_ren", ren_cnt_a, 0);
        check_eq("en_low_count", count_a, 8);
        en = 1'b1;
        c = 0;
        while (acc_cnt < 3 && c < 30) begin
            tick();
            c++;
        end
        check_range("en_burst_start", c, 0, 29);
        en = 1'b0;
        drain(60, "en_drain");
        check_eq("en_beats", acc_cnt, 8);
        check_eq("en_lasts", last_cnt, 1);
        en = 1'b1;

        // Reset after beat 4 of 8: remainder stays and is flushed later
        acc_cnt = 0;
        last_cnt = 0;
        expect_bursts(8);
        write_n(8, 8'h30);
        c = 0;
        while (!(acc_cnt == 3 && m_valid_a) && c < 40) begin
            tick();
            c++;
        end
        check_range("rstmid_reach_beat4", c, 0, 39);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstmid_m_valid", m_valid_a, 0);
        check_eq("rstmid_m_last", m_last_a, 0);
        check_eq("rstmid_busy", busy_a, 0);
        check_eq("rstmid_count", count_a, 4);
        check_eq("rstmid_accepted", acc_cnt, 4);
        blen_q.delete();
        blen_q.push_back(4);
        beat_idx = 0;
        drain(60, "rstmid_drain");
        check_eq("rstmid_beats", acc_cnt, 8);
        check_eq("rstmid_lasts", last_cnt, 1);
        check_eq("rstmid_empty", empty_a, 1);

        // Continuous stream: 1 word/cycle for 64 cycles
        acc_cnt = 0;
        last_cnt = 0;
        expect_bursts(64);
        maxgap = 0;
        fork
            write_n(64, 8'h00);
            begin
                gap = 0;
                started = 1'b0;
                c = 0;
                while (acc_cnt < 64 && c < 300) begin
                    if (m_valid_a) begin
                        started = 1'b1;
                        gap = 0;
                    end else if (started) begin
                        gap++;
                        if (gap > maxgap) maxgap = gap;
                    end
                    tick();
                    c++;
                end
            end
        join
        drain(60, "stream_drain");
        check_range("stream_max_gap", maxgap, 0, 2);
        check_eq("stream_beats", acc_cnt, 64);
        check_eq("stream_lasts", last_cnt, 8);
        check_eq("stream_empty", empty_a, 1);

        // Randomized: groups of 8 with random gaps, random back-pressure
        acc_cnt = 0;
        last_cnt = 0;
        rdy_mode = 1;
        expect_bursts(16 * 8);
        for (int g = 0; g < 16; g++) begin
            repeat ($urandom_range(0, 12)) tick();
            write_n(8, word_t'(g * 8 + 3));
        end
        drain(800, "rand_drain");
        check_eq("rand_beats", acc_cnt, 128);
        check_eq("rand_lasts", last_cnt, 16);
        check_eq("rand_empty", empty_a, 1);
        rdy_mode = 2;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side master for the team's synchronous show-ahead FIFO. It drains words through the FIFO's ren/rdata/empty/count port and emits them downstream as fixed-length bursts on a valid/ready stream, with a last marker on the final beat.
- A full burst starts when the FIFO holds at least BURST_LEN words.
- If fewer words sit in the FIFO for TIMEOUT cycles, a short flush burst carries whatever is there.
- Sits between a producer-side FIFO and a burst-oriented consumer, for example a DMA or packet framer.

Parameters:
- DTYPE, logic[7:0], word type; must match the FIFO's DTYPE.
- FIFO_DEPTH, 32, depth of the attached FIFO.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), FIFO address width; count is ADDR_WIDTH+1 bits.
- BURST_LEN, 8, beats per full burst; legal range 1..FIFO_DEPTH.
- TIMEOUT, 16, idle cycles with a non-empty FIFO before a flush burst; 0 disables flush.

Ports:
- clk, input, 1, clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, when low, no new burst starts; a burst in progress completes.
- fifo_ren, output, 1, pop strobe to the FIFO.
- fifo_rdata, input, DTYPE, FIFO head word, valid combinationally whenever !fifo_empty.
- fifo_empty, input, 1, FIFO empty flag.
- fifo_count, input, ADDR_WIDTH+1, FIFO occupancy.
- m_valid, output, 1, downstream beat valid.
- m_ready, input, 1, downstream accept.
- m_data, output, DTYPE, beat data.
- m_last, output, 1, final beat of the burst; qualified by m_valid.
- busy, output, 1, high while state is BURST.

Behaviour:
- Reset: rst is sampled at posedge clk. It forces state=IDLE, beats_left=0, wait_cnt=0, m_valid=0, m_last=0 and m_data=0. fifo_ren is combinational and is 0 while state=IDLE.
- States are IDLE and BURST.
- IDLE, full burst: if en and fifo_count>=BURST_LEN, load beats_left=BURST_LEN, go to BURST, clear wait_cnt.
- IDLE, flush:
  - if en and !fifo_empty and TIMEOUT!=0 and wait_cnt==TIMEOUT-1, load beats_left=fifo_count, go to BURST, clear wait_cnt.
  - Full-burst check wins when both conditions hold.
- IDLE, otherwise:
  - wait_cnt increments while !fifo_empty and en, saturating at TIMEOUT-1.
  - It clears when the FIFO is empty or en is low.
- BURST, pop rule: load = (!m_valid || m_ready) && beats_left!=0 && !fifo_empty. fifo_ren=load.
- BURST, on load:
  - m_data<=fifo_rdata, m_valid<=1, m_last<=(beats_left==1).
  - beats_left decrements.
  - When beats_left==1, go to IDLE in the same edge.
- Output register, both states: if m_valid && m_ready && !load, then m_valid<=0 and m_last<=0.
- Holding and throughput:
  - m_data, m_valid and m_last hold stable while m_valid && !m_ready.
  - Throughput is 1 beat/cycle when m_ready is held high.
  - Latency is 1 cycle from fifo_ren to m_valid.
- Back-to-back bursts:
  - A new burst may start in IDLE while the previous last beat is still held in the output register.
  - Its first pop waits on the same load rule.
- Counts and widths:
  - fifo_count is registered in the FIFO, so the snapshot taken in IDLE already reflects prior pops. Only this block pops, so beats_left<=fifo_count always holds.
  - fifo_empty during BURST with beats_left!=0 is a protocol error: assert in simulation and stall without popping.
  - beats_left is ADDR_WIDTH+1 bits and never underflows.
  - wait_cnt is $clog2(TIMEOUT+1) bits.
- Reset mid-burst: the partial burst is abandoned. No m_last is issued, the output beat is dropped, and unread words stay in the FIFO.
- en falling mid-burst has no effect until the burst ends.
- Simultaneous m_ready and load: the new beat replaces the old; m_valid stays 1.

Decomposition:
- Package fifo_burst_pkg holds the state enum typedef (IDLE, BURST) and a BURST_LEN<=FIFO_DEPTH elaboration check function.
- No sub-module; the output register is inline.
- Bench reuses generic_sync_fifo as the attached FIFO.

Test Plan:
- Full burst: write 8 words 0x10..0x17, m_ready=1 -> fifo_ren asserts within 2 cycles of count reaching 8. 8 consecutive m_valid beats carry 0x10..0x17, m_last only on 0x17, busy falls after the last pop.
- Back-pressure: 16 words, m_ready toggling 1,0,0,1 -> no beat is lost or duplicated, data is stable while stalled, two bursts each end with m_last, and the FIFO ends empty.
- Flush timeout: write 3 words 0xA0..0xA2, then nothing -> after 16 idle cycles a 3-beat burst is emitted with m_last on 0xA2. With TIMEOUT=0 nothing is emitted.
- en gating: 8 words present, en=0 -> no fifo_ren. en=1 -> burst runs. en dropped after beat 3 -> beats 4..8 still complete.
- Reset mid-burst: rst pulsed after beat 4 of 8 -> next cycle m_valid=0, m_last=0, busy=0. Remaining 4 words stay in the FIFO and are flushed after timeout.
- Continuous stream: writer pushes 1 word/cycle for 64 cycles, m_ready=1 -> 8 bursts of 8, in order, no gaps longer than 2 cycles between bursts.
